bmac_dot_ctrl: RTL and testbench
================================

# bmac_dot_ctrl

Sequencer for the binary XNOR datapath. It accepts a start command with a vector length, streams activation/weight word pairs through the external bitwise XNOR stage, and popcounts and accumulates the matches. It then emits one signed binary dot product per command (+1/−1 encoding) over a valid/ready handshake. It sits between the operand buffers and the downstream accumulate/threshold logic of the BMAC array.

## Interface
- IN_WIDTH, 32, bits per operand word; equals the XNOR stage width.
- LEN_WIDTH, 8, width of the word-count field.
- ACC_WIDTH, 16, signed result width. Must satisfy ACC_WIDTH ≥ clog2((2^LEN_WIDTH−1)·IN_WIDTH)+2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- vec_len  in  LEN_WIDTH  number of word pairs for the command; latched on accepted start.
- busy  out  1  high whenever state ≠ IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in RUN.
- act_in  in  IN_WIDTH  activation word.
- wgt_in  in  IN_WIDTH  weight word.
- xnor_in_0  out  IN_WIDTH  registered activation to the XNOR stage.
- xnor_in_1  out  IN_WIDTH  registered weight to the XNOR stage.
- xnor_out  in  IN_WIDTH  XNOR stage result (combinational from xnor_in_0/1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- dot_out  out  ACC_WIDTH  signed result, two's complement.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start with vec_len≠0: latch vec_len, clear word_cnt, acc and op_vld, go to RUN.
  - On start with vec_len=0: load dot_out=0 and go to DONE.
- RUN:
  - A word is accepted when in_valid && in_ready. On acceptance, act_in→xnor_in_0, wgt_in→xnor_in_1, op_vld←1, word_cnt+1.
  - Cycles with no acceptance set op_vld←0; xnor_in_0/1 hold their values.
  - Each cycle op_vld=1: acc ← acc + popcount(xnor_out), where popcount is 0..IN_WIDTH.
  - Accepting word number vec_len moves the state to DRAIN.
- DRAIN (exactly 1 cycle):
  - Adds the final popcount.
  - Loads dot_out ← 2·(acc + popcount(xnor_out)) − vec_len·IN_WIDTH, computed at ACC_WIDTH signed.
  - Clears op_vld and goes to DONE.
- DONE:
  - out_valid=1; dot_out stable until out_valid && out_ready.
  - On that handshake, go to IDLE. dot_out holds its value; out_valid drops.
- start is ignored outside IDLE, including in the DONE handshake cycle.
- acc is unsigned and needs no saturation, given the ACC_WIDTH rule.
- rst at any time: state=IDLE; acc, word_cnt, op_vld and the latched length cleared; partial results discarded.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, dot_out=0, xnor_in_0=0, xnor_in_1=0.
- After start in cycle C: busy=1 and in_ready=1 from cycle C+1.
- Throughput: one word pair per cycle with in_valid held high. A command of N words takes N RUN cycles + 1 DRAIN cycle; out_valid is high in cycle T+2, where T is the last-accept cycle.
- vec_len=0: out_valid high in cycle C+1; in_ready never asserts.
- in_ready deasserts in the cycle after the last accept (DRAIN), so an N-word command never accepts an (N+1)th word.
- After the out handshake in cycle H: IDLE at H+1, busy=0, and a new start is accepted in H+1 at the earliest.
- Back-pressure: out_valid and dot_out are held unchanged for any number of cycles with out_ready=0.

## Test plan
- vec_len=1, act=0xFFFFFFFF, wgt=0xFFFFFFFF, accepted in cycle T → out_valid at T+2, dot_out=+32, busy falls after the handshake.
- vec_len=2, act=0x00000000, wgt=0xFFFFFFFF both words → dot_out=−64 (0xFFC0 at ACC_WIDTH=16).
- vec_len=4, act=0xFFFF0000, wgt=0xFFFFFFFF, in_valid low for 3 cycles between each word → exactly 4 accepts, dot_out=0, in_ready low during DRAIN/DONE.
- vec_len=0 start → out_valid the next cycle with dot_out=0; in_ready stays 0 throughout.
- Result pending with out_ready=0 for 5 cycles, start pulsed during the wait → out_valid/dot_out stable and start ignored. Assert out_ready → IDLE next cycle; a following start is accepted.
- rst asserted after 2 of 4 words → all outputs at reset values the next cycle. New start vec_len=1 with matching all-ones words → dot_out=+32, no residue from the aborted command.

Source files
------------

// File: rtl/bmac_dot_ctrl.sv
// bmac_dot_ctrl: sequences operand word pairs through an external XNOR stage,
// popcounts and accumulates the matches, then emits the signed (+1/-1) dot product.
// Latency: an N-word command gives out_valid 2 cycles after its last accepted word.
// Backpressure: in_ready only in RUN; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, vec_len, busy   command strobe (sampled in IDLE), word count, busy flag
//   in_valid/in_ready      operand pair handshake carrying act_in / wgt_in
//   xnor_in_0/1, xnor_out  registered operands to, and result from, the XNOR stage
//   out_valid/out_ready    result handshake carrying dot_out
module bmac_dot_ctrl #(
  parameter int IN_WIDTH  = 32,
  parameter int LEN_WIDTH = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  act_in,
  input  logic [IN_WIDTH-1:0]  wgt_in,
  output logic [IN_WIDTH-1:0]  xnor_in_0,
  output logic [IN_WIDTH-1:0]  xnor_in_1,
  input  logic [IN_WIDTH-1:0]  xnor_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] dot_out
);

  localparam int PCW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 op_vld;   // xnor_in_0/1 hold a pair whose popcount is still owed
  logic [PCW-1:0]       pc;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [ACC_WIDTH-1:0] dot_calc;
  logic                 accept;

  always_comb begin
    pc = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      pc = pc + PCW'(xnor_out[i]);
    end
  end

  assign acc_sum = acc + ACC_WIDTH'(pc);
  // matches count +1 and mismatches -1, so dot = 2*matches - total_bits
  assign dot_calc = (acc_sum << 1) - (ACC_WIDTH'(len_q) * ACC_WIDTH'(IN_WIDTH));

  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      word_cnt  <= '0;
      acc       <= '0;
      op_vld    <= 1'b0;
      xnor_in_0 <= '0;
      xnor_in_1 <= '0;
      dot_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (vec_len != '0) begin
              len_q    <= vec_len;
              word_cnt <= '0;
              acc      <= '0;
              op_vld   <= 1'b0;
              state    <= RUN;
            end else begin
              dot_out <= '0;
              state   <= DONE;
            end
          end
        end
        RUN: begin
          // popcount of the pair registered last cycle is folded in one cycle later
          if (op_vld) acc <= acc_sum;
          op_vld <= accept;
          if (accept) begin
            xnor_in_0 <= act_in;
            xnor_in_1 <= wgt_in;
            word_cnt  <= word_cnt + LEN_WIDTH'(1);
            if (word_cnt == len_q - LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // last pair is always pending here
          acc     <= acc_sum;
          dot_out <= dot_calc;
          op_vld  <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmac_dot_ctrl.sv
module tb_bmac_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  vec_len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] act_in;
  logic [31:0] wgt_in;
  logic [31:0] xnor_in_0;
  logic [31:0] xnor_in_1;
  logic [31:0] xnor_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dot_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] act_q[$];
  logic [31:0] wgt_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external XNOR stage
  assign xnor_out = ~(xnor_in_0 ^ xnor_in_1);

  bmac_dot_ctrl #(.IN_WIDTH(32), .LEN_WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wgt_in(wgt_in),
    .xnor_in_0(xnor_in_0), .xnor_in_1(xnor_in_1), .xnor_out(xnor_out),
    .out_valid(out_valid), .out_ready(out_ready), .dot_out(dot_out)
  );

  // reference: each bit contributes +1 if the operands agree, -1 otherwise
  function automatic logic [15:0] model_dot(input int len);
    int s;
    s = 0;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 32; b++) begin
        s += (act_q[i][b] == wgt_q[i][b]) ? 1 : -1;
      end
    end
    return 16'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issues a command and streams act_q/wgt_q; gap<0 means random idle cycles.
  // Keeps in_valid high with junk after the last word so extra accepts show up.
  task automatic run_cmd(input int len, input int gap, output int n_acc, output int lat,
                         output bit tmo, output bit rdy_bad, output bit busy_bad);
    int idx, idle, t_last, budget;
    n_acc = 0; idx = 0; idle = 0; tmo = 0; rdy_bad = 0; busy_bad = 0; budget = 0;
    start = 1'b1; vec_len = 8'(len); in_valid = 1'b0;
    t_last = cyc;
    tick();
    start = 1'b0;
    if (busy !== 1'b1) busy_bad = 1;
    if (len > 0 && in_ready !== 1'b1) busy_bad = 1;
    while (out_valid !== 1'b1) begin
      if (budget > 400) begin tmo = 1; break; end
      budget++;
      if (idx >= len && in_ready === 1'b1) rdy_bad = 1;
      if (idx < len) begin
        if (idle > 0) begin
          in_valid = 1'b0; idle--;
        end else begin
          in_valid = 1'b1; act_in = act_q[idx]; wgt_in = wgt_q[idx];
        end
      end else begin
        in_valid = 1'b1; act_in = $urandom; wgt_in = $urandom;
      end
      if (in_valid && in_ready === 1'b1) begin
        n_acc++;
        if (idx < len) begin
          idx++;
          t_last = cyc;
          idle = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    lat = cyc - t_last;
  endtask

  task automatic ack(input int hold);
    out_ready = 1'b0;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic fill(input int len, input logic [31:0] a, input logic [31:0] w);
    act_q.delete(); wgt_q.delete();
    for (int i = 0; i < len; i++) begin act_q.push_back(a); wgt_q.push_back(w); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    act_in = '0; wgt_in = '0;
    tick(); tick();
    n_checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || dot_out !== 16'h0 ||
        xnor_in_0 !== 32'h0 || xnor_in_1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values busy=%b in_ready=%b out_valid=%b dot=%h x0=%h x1=%h expected all zero",
               busy, in_ready, out_valid, dot_out, xnor_in_0, xnor_in_1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n_acc, lat; bit tmo, rb, bb;
    fill(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_cmd(1, 0, n_acc, lat, tmo, rb, bb);
    n_checks++;
    if (tmo || lat != 2 || n_acc != 1 || rb || bb) begin
      n_fail++;
      $display("FAIL single_timing tmo=%0d lat=%0d acc=%0d rdy_bad=%0d busy_bad=%0d expected 0/2/1/0/0",
               tmo, lat, n_acc, rb, bb);
    end
    n_checks++;
    if (dot_out !== 16'd32) begin
      n_fail++; $display("FAIL single_dot got=%h expected=%h", dot_out, 16'd32);
    end
    ack(0);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || dot_out !== 16'd32) begin
      n_fail++;
      $display("FAIL single_after_ack busy=%b out_valid=%b dot=%h expected 0/0/0020", busy, out_valid, dot_out);
    end
  endtask

  task automatic test_all_mismatch();
    int n_acc, lat; bit tmo, rb, bb;
    fill(2, 32'h0, 32'hFFFF_FFFF);
    run_cmd(2, 0, n_acc, lat, tmo, rb, bb);
    n_checks++;
    if (tmo || dot_out !== 16'hFFC0 || lat != 2 || n_acc != 2) begin
      n_fail++;
      $display("FAIL mismatch_dot got=%h lat=%0d acc=%0d tmo=%0d expected ffc0/2/2/0", dot_out, lat, n_acc, tmo);
    end
    ack(1);
  endtask

  task automatic test_gaps();
    int n_acc, lat; bit tmo, rb, bb;
    fill(4, 32'hFFFF_0000, 32'hFFFF_FFFF);
    run_cmd(4, 3, n_acc, lat, tmo, rb, bb);
    n_checks++;
    if (tmo || n_acc != 4 || rb) begin
      n_fail++;
      $display("FAIL gaps_accepts tmo=%0d accepts=%0d rdy_bad=%0d expected 0/4/0", tmo, n_acc, rb);
    end
    n_checks++;
    if (dot_out !== 16'h0 || lat != 2) begin
      n_fail++; $display("FAIL gaps_dot got=%h lat=%0d expected 0000/2", dot_out, lat);
    end
    ack(2);
  endtask

  task automatic test_zero_len();
    int n_acc, lat; bit tmo, rb, bb;
    run_cmd(0, 0, n_acc, lat, tmo, rb, bb);
    n_checks++;
    if (tmo || lat != 1 || dot_out !== 16'h0 || rb || n_acc != 0) begin
      n_fail++;
      $display("FAIL zero_len tmo=%0d lat=%0d dot=%h rdy_bad=%0d acc=%0d expected 0/1/0000/0/0",
               tmo, lat, dot_out, rb, n_acc);
    end
    ack(0);
  endtask

  task automatic test_backpressure();
    int n_acc, lat; bit tmo, rb, bb, bad;
    logic [15:0] exp;
    fill(3, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin act_q[i] = $urandom; wgt_q[i] = $urandom; end
    act_q[0] = 32'hFFFF_FFFF; wgt_q[0] = 32'hFFFF_FFFF;  // keep the result nonzero-biased
    exp = model_dot(3);
    run_cmd(3, 0, n_acc, lat, tmo, rb, bb);
    bad = tmo;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); vec_len = 8'd5;
      if (out_valid !== 1'b1 || dot_out !== exp) bad = 1;
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (bad || out_valid !== 1'b1 || dot_out !== exp) begin
      n_fail++;
      $display("FAIL backpressure_hold out_valid=%b dot=%h expected 1/%h", out_valid, dot_out, exp);
    end
    // start in the handshake cycle itself must be ignored
    out_ready = 1'b1; start = 1'b1; vec_len = 8'd1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || dot_out !== exp) begin
      n_fail++;
      $display("FAIL backpressure_release busy=%b out_valid=%b dot=%h expected 0/0/%h", busy, out_valid, dot_out, exp);
    end
    fill(1, 32'h1234_5678, 32'h1234_5678);
    run_cmd(1, 0, n_acc, lat, tmo, rb, bb);
    n_checks++;
    if (tmo || bb || dot_out !== 16'd32) begin
      n_fail++; $display("FAIL backpressure_next got=%h tmo=%0d busy_bad=%0d expected 0020/0/0", dot_out, tmo, bb);
    end
    ack(0);
  endtask

  task automatic test_random();
    int n_acc, lat, len; bit tmo, rb, bb;
    logic [15:0] exp;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 12);
      act_q.delete(); wgt_q.delete();
      for (int i = 0; i < len; i++) begin act_q.push_back($urandom); wgt_q.push_back($urandom); end
      exp = model_dot(len);
      run_cmd(len, -1, n_acc, lat, tmo, rb, bb);
      n_checks++;
      if (tmo || dot_out !== exp || n_acc != len || lat != 2 || rb || bb) begin
        n_fail++;
        $display("FAIL random_%0d len=%0d got=%h expected=%h acc=%0d lat=%0d tmo=%0d rb=%0d bb=%0d",
                 k, len, dot_out, exp, n_acc, lat, tmo, rb, bb);
      end
      ack($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    int n_acc, lat; bit tmo, rb, bb;
    start = 1'b1; vec_len = 8'd4;
    tick();
    start = 1'b0; in_valid = 1'b1; act_in = 32'h0; wgt_in = 32'hFFFF_FFFF;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || dot_out !== 16'h0 ||
        xnor_in_0 !== 32'h0 || xnor_in_1 !== 32'h0) begin
      n_fail++;
      $display("FAIL midrun_reset busy=%b in_ready=%b out_valid=%b dot=%h x0=%h x1=%h expected all zero",
               busy, in_ready, out_valid, dot_out, xnor_in_0, xnor_in_1);
    end
    rst = 1'b0;
    tick();
    fill(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_cmd(1, 0, n_acc, lat, tmo, rb, bb);
    n_checks++;
    if (tmo || dot_out !== 16'd32 || n_acc != 1 || lat != 2) begin
      n_fail++;
      $display("FAIL after_reset_dot got=%h acc=%0d lat=%0d tmo=%0d expected 0020/1/2/0", dot_out, n_acc, lat, tmo);
    end
    ack(0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_mismatch();
    test_gaps();
    test_zero_len();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
